// File: rtl/button_repeat_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// button_repeat_pkg
// Shared definitions for the button_repeat block and its tick prescaler.
//   state_t : per-channel FSM state (IDLE = 0, DELAY = 1, REPEAT = 2)
//   clog2   : ceiling log2, used to size counters from their maximum count
// ---------------------------------------------------------------------------
package button_repeat_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   // Number of bits needed to represent the values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/button_repeat_tick.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// button_repeat_tick
// Free-running prescaler that produces a one-cycle tick every TICK_DIV
// clock cycles. It can be shared by any timed GPIO block.
// Ports:
//   clk     : core clock
//   reset_n : asynchronous active-low reset
//   tick    : high for one cycle when the prescaler reaches TICK_DIV-1
// ---------------------------------------------------------------------------
module button_repeat_tick
   import button_repeat_pkg::*;
#(
   parameter int TICK_DIV = 125000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int CNT_W = clog2(TICK_DIV);

   logic [CNT_W-1:0] count;

   // Counter starts at 0 after reset, so the first tick lands in cycle
   // TICK_DIV-1 after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (count == CNT_W'(TICK_DIV - 1)) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign tick = (count == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/button_repeat.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// button_repeat
// Turns debounced button levels into single-cycle press, release and event
// pulses. While a button is held, event repeats: once on press, once after
// HOLD_TICKS ticks, then every REPEAT_TICKS ticks (only on channels whose
// REPEAT_MASK bit is set).
// Ports:
//   clk           : core clock
//   reset_n       : asynchronous active-low reset
//   in            : debounced button levels, 1 = pressed
//   press         : one-cycle pulse when a channel is pressed
//   release_pulse : one-cycle pulse when a channel is released
//   event_pulse   : one-cycle pulse on press and on every repeat
//   held          : level, 1 while a channel is armed (DELAY or REPEAT)
// The release and event outputs carry a _pulse suffix because release and
// event are reserved words in SystemVerilog.
// ---------------------------------------------------------------------------
module button_repeat
   import button_repeat_pkg::*;
#(
   parameter int               WIDTH        = 5,
   parameter int               TICK_DIV     = 125000,
   parameter int               HOLD_TICKS   = 500,
   parameter int               REPEAT_TICKS = 100,
   parameter logic [WIDTH-1:0] REPEAT_MASK  = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] press,
   output logic [WIDTH-1:0] release_pulse,
   output logic [WIDTH-1:0] event_pulse,
   output logic [WIDTH-1:0] held
);

   localparam int MAX_TICKS = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int CNT_W     = clog2(MAX_TICKS + 1);

   logic tick;
   logic primed;

   button_repeat_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   // The first cycle after reset only captures the input levels, so a button
   // held through reset is not mistaken for a fresh press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         primed <= 1'b0;
      end else begin
         primed <= 1'b1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan

      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] count;
      logic [CNT_W-1:0] count_nxt;
      logic             in_d;
      logic             rise;
      logic             fall;
      logic             press_nxt;
      logic             release_nxt;
      logic             event_nxt;
      logic             press_q;
      logic             release_q;
      logic             event_q;
      logic             held_q;

      assign rise = primed &  in[i] & ~in_d;
      assign fall = primed & ~in[i] &  in_d;

      // Channel registers; every output is registered so pulses appear one
      // cycle after the edge that caused them.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            in_d      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            event_q   <= 1'b0;
            held_q    <= 1'b0;
         end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            in_d      <= in[i];
            press_q   <= press_nxt;
            release_q <= release_nxt;
            event_q   <= event_nxt;
            held_q    <= (state_nxt != ST_IDLE);
         end
      end

      // Next-state logic. A fall is handled before anything else so that a
      // release coinciding with a repeat expiry produces only the release.
      // On a press the counter is loaded without looking at tick, so a tick
      // in the press cycle never shortens the hold delay.
      always_comb begin
         state_nxt   = state;
         count_nxt   = count;
         press_nxt   = 1'b0;
         release_nxt = 1'b0;
         event_nxt   = 1'b0;

         if (fall) begin
            release_nxt = 1'b1;
            count_nxt   = '0;
            state_nxt   = ST_IDLE;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (rise) begin
                     press_nxt = 1'b1;
                     event_nxt = 1'b1;
                     count_nxt = CNT_W'(HOLD_TICKS);
                     state_nxt = ST_DELAY;
                  end
               end
               ST_DELAY: begin
                  if (tick && REPEAT_MASK[i]) begin
                     if (count == CNT_W'(1)) begin
                        event_nxt = 1'b1;
                        count_nxt = CNT_W'(REPEAT_TICKS);
                        state_nxt = ST_REPEAT;
                     end else if (count > CNT_W'(1)) begin
                        count_nxt = count - CNT_W'(1);
                     end
                  end
               end
               ST_REPEAT: begin
                  if (tick) begin
                     if (count == CNT_W'(1)) begin
                        event_nxt = 1'b1;
                        count_nxt = CNT_W'(REPEAT_TICKS);
                     end else if (count > CNT_W'(1)) begin
                        count_nxt = count - CNT_W'(1);
                     end
                  end
               end
               default: begin
                  count_nxt = '0;
                  state_nxt = ST_IDLE;
               end
            endcase
         end
      end

      assign press[i]         = press_q;
      assign release_pulse[i] = release_q;
      assign event_pulse[i]   = event_q;
      assign held[i]          = held_q;

   end

endmodule

// File: doc/button_repeat.md
# button_repeat

Per-button event generator between the debounced GPIO inputs (the `debounce_switch` outputs) and `fpga_core`. It converts level-stable button signals into single-cycle press, release and event pulses. Event pulses repeat automatically while a button is held: a first event on press, a second after an initial hold delay, then one per repeat period. All timing comes from a shared millisecond-class tick derived from the 125 MHz core clock.

## Interface
- `WIDTH`, 5: number of button channels.
- `TICK_DIV`, 125000: clock cycles per tick; 1 ms at 125 MHz; must be ≥2.
- `HOLD_TICKS`, 500: ticks from press to the first repeat event; must be ≥1.
- `REPEAT_TICKS`, 100: ticks between subsequent repeat events; must be ≥1.
- `REPEAT_MASK`, {WIDTH{1'b1}}: bit i = 1 enables auto-repeat on channel i.

Ports:
- `clk`  in  1  core clock (125 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `in`  in  WIDTH  debounced button levels, synchronous to `clk`, 1 = pressed.
- `press`  out  WIDTH  one-cycle pulse on press.
- `release`  out  WIDTH  one-cycle pulse on release.
- `event`  out  WIDTH  one-cycle pulse on press and on each repeat.
- `held`  out  WIDTH  level, 1 while the channel is pressed and armed (DELAY or REPEAT).

## Operation
- Tick prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - `tick` is high for one cycle when the counter equals TICK_DIV-1.
  - Reset value 0, so the first tick occurs in cycle TICK_DIV-1 after reset release.
- Priming: the first cycle after reset release loads `in_d` from `in` and generates no events. A button held through reset stays IDLE until it is released and pressed again.
- Per channel:
  - Registers: `in_d`, a 2-bit state, and a tick counter sized to hold max(HOLD_TICKS, REPEAT_TICKS).
  - States: IDLE, DELAY, REPEAT.
  - IDLE, rise (`in` & ~`in_d`): pulse `press` and `event`, load the counter with HOLD_TICKS, go to DELAY.
  - DELAY, tick, counter == 1, mask bit set: pulse `event`, load the counter with REPEAT_TICKS, go to REPEAT.
  - DELAY, tick, counter > 1: decrement the counter.
  - DELAY, mask bit clear: the counter is frozen and no repeat events are generated.
  - REPEAT, tick, counter == 1: pulse `event` and reload REPEAT_TICKS.
  - REPEAT, tick, counter > 1: decrement the counter.
  - Any state, fall (~`in` & `in_d`): pulse `release`, clear the counter, go to IDLE.
- Simultaneous events:
  - Fall and expiry in the same cycle: the fall wins. `release` pulses and `event` does not.
  - Rise and tick in the same cycle: the tick does not decrement the freshly loaded counter.
- Channels are fully independent; any combination of channels may pulse in the same cycle.

## Timing
- All outputs are registered. Reset values: `press`, `release`, `event` and `held` are all 0.
- Press latency: `in` sampled 1 at edge N with `in_d` = 0 → `press`/`event` high for the cycle after edge N (1-cycle latency). `held` rises in the same cycle.
- Release latency: 1 cycle; `held` falls in the same cycle `release` pulses.
- First repeat `event` timing after `press`: it arrives at the HOLD_TICKS-th tick that follows the press cycle. That puts it between (HOLD_TICKS-1)·TICK_DIV+1 and HOLD_TICKS·TICK_DIV cycles after `press`.
- Later repeats: exactly REPEAT_TICKS·TICK_DIV cycles apart.
- Asynchronous reset assertion mid-hold clears all state and outputs immediately. No pulse is emitted when reset deasserts.

## Structure
- Shared package `button_repeat_pkg`:
  - state encodings IDLE = 0, DELAY = 1, REPEAT = 2;
  - the clog2 function used for counter widths.
- Sub-module `button_repeat_tick`: parameterised prescaler (TICK_DIV), ports `clk`, `reset_n`, `tick`. It is reusable by other timed GPIO blocks.
- Per-channel logic sits in a generate loop in `button_repeat`.

## Test plan
Bench parameters: WIDTH=2, TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2, REPEAT_MASK=2'b01.
- Reset: hold `reset_n`=0 with `in`=2'b11, release → no `press` for 20 cycles. Drop `in`[0], raise it again → `press`[0] pulses once, 1 cycle after the rise.
- Hold ch0 for 40 cycles after a press aligned 1 cycle after a tick:
  - first `event` at the press;
  - second `event` 12 cycles later;
  - then one every 8 cycles;
  - `held`[0] = 1 throughout.
- Hold ch1 (mask 0) for 40 cycles → exactly one `event`[1] and one `press`[1]. On release: `release`[1] pulses, `held`[1] falls in the same cycle.
- Release ch0 on the same cycle its repeat would fire → `release`[0] pulses, no `event`[0], state returns to IDLE.
- Assert `reset_n`=0 mid-REPEAT → all outputs are 0 within the same cycle. After deassert with `in`[0] still 1, no pulses occur.
- Random press/release on both channels versus a reference model: pulse counts and cycle positions match exactly.
